alu_division_block: RTL and testbench
=====================================

# alu_division_block

Iterative RV64M divide/remainder unit, the inverse companion of the pipelined multiplier in the execute stage. It accepts one DIV/DIVU/REM/REMU (and W-form) request per operation from the ALU control decode. It computes the result with a radix-2 restoring shift-subtract loop and returns a registered 64-bit result with a one-cycle valid pulse. A busy flag tells the issue logic to hold further division requests.

## Interface
- No parameters; datapath fixed at 64 bits, W-forms at 32 bits.
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid  input  1  request qualifier from decode.
- alu_control  input  5  operation code: 16 DIV, 17 DIVU, 18 REM, 19 REMU, 20 DIVW, 21 DIVUW, 22 REMW, 23 REMUW; all other codes ignored.
- op1_data  input  64  dividend.
- op2_data  input  64  divisor.
- alu_output  output  64  registered result; holds until next completion.
- alu_valid  output  1  registered one-cycle pulse; alu_output valid while high.
- busy  output  1  high while a division is in progress.

## Operation
- Accept when valid && 16<=alu_control<=23 && !busy. Requests while busy are dropped, not queued; issue must stall on busy.
- Operand prep at accept:
  - 64-bit forms use full operands.
  - W-forms use op[31:0], sign-extended (DIVW/REMW) or zero-extended (DIVUW/REMUW).
  - Signed forms convert to magnitudes and latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
- Special cases resolve at accept and never enter CALC:
  - Divisor zero: quotient all ones; remainder = dividend.
  - Signed overflow: most-negative / -1 gives quotient = dividend and remainder 0. Most-negative is 0x8000000000000000, or 0x80000000 for W-forms.
- FSM states:
  - IDLE: on non-special accept, load magnitudes, count = N (64, or 32 for W), go to CALC.
  - CALC: one step per edge: shift {rem, quo} left 1; if rem >= divisor, subtract and set quotient LSB. Decrement count. On the step where count goes 1->0, write the final result and return to IDLE.
- Result fixup: negate quotient if sign_q; negate remainder if sign_r. Select quotient for DIV* and remainder for REM*. W-forms sign-extend result bit 31 to 64 bits, including DIVUW/REMUW.
- Unsigned forms never negate.
- busy = (state == CALC).

## Timing
- Reset (asynchronous, any state, including mid-CALC): state IDLE, alu_output 0, alu_valid 0, busy 0, count 0. The operation in flight is discarded with no alu_valid.
- Request presented in cycle 0 and accepted at edge 0:
  - Special case: alu_valid high in cycle 1.
  - 64-bit: busy high cycles 1-64, alu_valid high in cycle 65.
  - W-form: busy high cycles 1-32, alu_valid high in cycle 33.
- busy is low in the alu_valid cycle, so a new request may be accepted in that cycle, giving back-to-back throughput of N+1 cycles.
- alu_valid is high for exactly one cycle per accepted request. alu_output is stable from the alu_valid cycle until the next completion.
- A request in the same cycle as a completion is accepted normally. The completion pulse is unaffected.
- Non-division codes with valid high: no state change, no alu_valid.

## Test plan
- DIV 20 / -3 (code 16): alu_valid in cycle 65, output 0xFFFFFFFFFFFFFFFA (-6). Then REM 20 / -3 (code 18): output 2.
- DIVU by zero (code 17, op1 = 0x1234): alu_valid in cycle 1, output 0xFFFFFFFFFFFFFFFF. REMU by zero (code 19): output 0x1234.
- Overflow DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF: output 0x8000000000000000, latency 1. REM of the same operands: output 0.
- DIVUW op1 = 0xFFFFFFFF_FFFFFFFE, op2 = 1: alu_valid in cycle 33, output 0xFFFFFFFFFFFFFFFE (sign-extended 0xFFFFFFFE). REMW -7 / 2: output 0xFFFFFFFFFFFFFFFF.
- Second request issued in cycle 10 of a 64-bit DIVU 100 / 7: dropped. Single alu_valid in cycle 65 with output 14. A request held through cycle 65 is accepted there and completes in cycle 130.
- Assert rst in cycle 30 of a DIV: all outputs 0 immediately, no alu_valid. A fresh DIVU 9 / 3 after release returns 3 after 65 cycles.

Source files
------------

// File: rtl/alu_division_block.sv
// Iterative RV64M divide/remainder unit: radix-2 restoring shift-subtract,
// one quotient bit per cycle, registered result with a one-cycle valid pulse.
module alu_division_block (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [4:0]  alu_control,
    input  logic [63:0] op1_data,
    input  logic [63:0] op2_data,
    output logic [63:0] alu_output,
    output logic        alu_valid,
    output logic        busy
);

    typedef enum logic {IDLE, CALC} state_t;

    state_t      state;
    logic [63:0] rem_reg;
    logic [63:0] quo_reg;
    logic [63:0] div_reg;
    logic [6:0]  count;
    logic        sign_q;
    logic        sign_r;
    logic        sel_rem;
    logic        is_w_reg;

    // Codes 16..23 share the 5'b10xxx prefix: bit 2 = W-form, bit 1 = REM, bit 0 = unsigned.
    logic is_div_op;
    logic op_w;
    logic op_rem;
    logic op_unsigned;
    logic accept;

    assign is_div_op   = (alu_control[4:3] == 2'b10);
    assign op_w        = alu_control[2];
    assign op_rem      = alu_control[1];
    assign op_unsigned = alu_control[0];
    assign accept      = valid && is_div_op && (state == IDLE);
    assign busy        = (state == CALC);

    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        neg_dividend;
    logic        neg_divisor;
    logic [63:0] mag_dividend;
    logic [63:0] mag_divisor;
    logic        div_zero;
    logic        overflow;
    logic [63:0] most_neg;
    logic [63:0] special_raw;
    logic [63:0] special_result;

    always_comb begin
        if (op_w) begin
            dividend = op_unsigned ? {32'b0, op1_data[31:0]} : {{32{op1_data[31]}}, op1_data[31:0]};
            divisor  = op_unsigned ? {32'b0, op2_data[31:0]} : {{32{op2_data[31]}}, op2_data[31:0]};
            most_neg = 64'hFFFF_FFFF_8000_0000;
        end else begin
            dividend = op1_data;
            divisor  = op2_data;
            most_neg = 64'h8000_0000_0000_0000;
        end
        neg_dividend = !op_unsigned && dividend[63];
        neg_divisor  = !op_unsigned && divisor[63];
        mag_dividend = neg_dividend ? -dividend : dividend;
        mag_divisor  = neg_divisor ? -divisor : divisor;
        div_zero     = (divisor == 64'd0);
        overflow     = !op_unsigned && (dividend == most_neg) && (divisor == 64'hFFFF_FFFF_FFFF_FFFF);
        // Divide-by-zero and signed overflow bypass the iterative loop entirely.
        if (div_zero)
            special_raw = op_rem ? dividend : 64'hFFFF_FFFF_FFFF_FFFF;
        else
            special_raw = op_rem ? 64'd0 : dividend;
        special_result = op_w ? {{32{special_raw[31]}}, special_raw[31:0]} : special_raw;
    end

    logic [64:0] trial;
    logic        fits;
    logic [63:0] next_rem;
    logic [63:0] next_quo;
    logic [63:0] quo_fixed;
    logic [63:0] rem_fixed;
    logic [63:0] raw_result;
    logic [63:0] final_result;

    // A fitting trial is below 2*divisor, so the 64-bit wrapped difference is exact.
    always_comb begin
        trial        = {rem_reg, quo_reg[63]};
        fits         = (trial >= {1'b0, div_reg});
        next_rem     = fits ? (trial[63:0] - div_reg) : trial[63:0];
        next_quo     = {quo_reg[62:0], fits};
        quo_fixed    = sign_q ? -next_quo : next_quo;
        rem_fixed    = sign_r ? -next_rem : next_rem;
        raw_result   = sel_rem ? rem_fixed : quo_fixed;
        final_result = is_w_reg ? {{32{raw_result[31]}}, raw_result[31:0]} : raw_result;
    end

    // W-forms park the 32-bit dividend in the top half so 32 shifts consume it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            alu_output <= 64'd0;
            alu_valid  <= 1'b0;
            count      <= 7'd0;
            rem_reg    <= 64'd0;
            quo_reg    <= 64'd0;
            div_reg    <= 64'd0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            sel_rem    <= 1'b0;
            is_w_reg   <= 1'b0;
        end else begin
            alu_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_zero || overflow) begin
                            alu_output <= special_result;
                            alu_valid  <= 1'b1;
                        end else begin
                            rem_reg  <= 64'd0;
                            quo_reg  <= op_w ? {mag_dividend[31:0], 32'd0} : mag_dividend;
                            div_reg  <= mag_divisor;
                            count    <= op_w ? 7'd32 : 7'd64;
                            sign_q   <= neg_dividend ^ neg_divisor;
                            sign_r   <= neg_dividend;
                            sel_rem  <= op_rem;
                            is_w_reg <= op_w;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= next_rem;
                    quo_reg <= next_quo;
                    count   <= count - 7'd1;
                    if (count == 7'd1) begin
                        alu_output <= final_result;
                        alu_valid  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_division_block.sv
// Directed and randomized checks of alu_division_block against an arithmetic
// reference model of RV64M DIV/REM semantics and cycle-level latency.
module tb_alu_division_block;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [4:0]  alu_control;
    logic [63:0] op1_data;
    logic [63:0] op2_data;
    logic [63:0] alu_output;
    logic        alu_valid;
    logic        busy;

    int tests_run;
    int tests_failed;

    alu_division_block dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .alu_control (alu_control),
        .op1_data    (op1_data),
        .op2_data    (op2_data),
        .alu_output  (alu_output),
        .alu_valid   (alu_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] code, input logic [63:0] a, input logic [63:0] b);
        valid       = v;
        alu_control = code;
        op1_data    = a;
        op2_data    = b;
    endtask

    // Reference: RISC-V M-extension rules expressed with native integer arithmetic.
    function automatic void model(input logic [4:0] code, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] res, output int lat);
        bit          w;
        bit          is_signed;
        bit          want_rem;
        bit          special;
        int          a32;
        int          b32;
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] q;
        logic [63:0] r;
        w         = (code >= 5'd20);
        is_signed = ((code - 5'd16) % 2) == 0;
        want_rem  = ((code - 5'd16) % 4) >= 2;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            sa  = a32;
            sb  = b32;
            ua  = {32'd0, a[31:0]};
            ub  = {32'd0, b[31:0]};
        end else begin
            sa = a;
            sb = b;
            ua = a;
            ub = b;
        end
        special = 1'b0;
        if (is_signed) begin
            if (sb == 0) begin
                q = '1; r = sa; special = 1'b1;
            end else if (sb == -1 && ((w && sa == -64'sd2147483648) || (!w && sa == 64'sh8000_0000_0000_0000))) begin
                q = sa; r = 64'd0; special = 1'b1;
            end else begin
                q = sa / sb; r = sa % sb;
            end
        end else begin
            if (ub == 0) begin
                q = '1; r = ua; special = 1'b1;
            end else begin
                q = ua / ub; r = ua % ub;
            end
        end
        res = want_rem ? r : q;
        if (w) res = {{32{res[31]}}, res[31:0]};
        lat = special ? 1 : (w ? 33 : 65);
    endfunction

    // Issue one request in cycle 0 and follow it to its completion pulse.
    task automatic runOp(input string tag, input logic [4:0] code, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_val, input int exp_lat);
        int cyc;
        applyStimulus(1'b1, code, a, b);
        @(posedge clk); #1;
        cyc = 1;
        valid = 1'b0;
        while (!alu_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        checkOutput({tag, " result"}, alu_output, exp_val);
        checkOutput({tag, " busy at completion"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        checkOutput({tag, " pulse width"}, 64'(alu_valid), 64'd0);
        checkOutput({tag, " output hold"}, alu_output, exp_val);
    endtask

    initial begin
        logic [63:0] exp_val;
        int          exp_lat;
        int          pulses;
        logic [4:0]  code;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] held;
        int          pattern;

        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 64'd0, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset alu_output", alu_output, 64'd0);
        checkOutput("reset alu_valid", 64'(alu_valid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        runOp("DIV 20/-3", 5'd16, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 65);
        runOp("REM 20/-3", 5'd18, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 65);
        runOp("DIVU by zero", 5'd17, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        runOp("REMU by zero", 5'd19, 64'h1234, 64'd0, 64'h1234, 1);
        runOp("DIV overflow", 5'd16, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        runOp("REM overflow", 5'd18, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        runOp("DIVUW", 5'd21, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        runOp("REMW -7/2", 5'd22, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);

        // A non-division code must leave the unit untouched.
        held = alu_output;
        applyStimulus(1'b1, 5'd3, 64'd40, 64'd0);
        @(posedge clk); #1;
        valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput("non-div alu_valid", 64'(alu_valid), 64'd0);
            checkOutput("non-div busy", 64'(busy), 64'd0);
        end
        checkOutput("non-div output held", alu_output, held);

        // Request while busy is dropped; one held through the completion cycle is taken there.
        pulses = 0;
        applyStimulus(1'b1, 5'd17, 64'd100, 64'd7);
        for (int c = 1; c <= 135; c++) begin
            @(posedge clk); #1;
            if (alu_valid) pulses++;
            if (c == 10) checkOutput("drop busy", 64'(busy), 64'd1);
            if (c == 65) begin
                checkOutput("drop first pulse", 64'(alu_valid), 64'd1);
                checkOutput("drop first result", alu_output, 64'd14);
            end
            if (c == 130) begin
                checkOutput("held second pulse", 64'(alu_valid), 64'd1);
                checkOutput("held second result", alu_output, 64'd9);
            end
            if (c == 10)
                applyStimulus(1'b1, 5'd17, 64'd50, 64'd5);
            else if (c >= 60 && c <= 65)
                applyStimulus(1'b1, 5'd17, 64'd81, 64'd9);
            else
                valid = 1'b0;
        end
        checkOutput("drop pulse count", 64'(pulses), 64'd2);

        // Reset in the middle of CALC discards the operation.
        applyStimulus(1'b1, 5'd16, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD);
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        checkOutput("mid reset alu_output", alu_output, 64'd0);
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset alu_valid", 64'(alu_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            if (alu_valid) pulses++;
        end
        checkOutput("mid reset no pulse", 64'(pulses), 64'd0);
        runOp("DIVU 9/3 after reset", 5'd17, 64'd9, 64'd3, 64'd3, 65);

        for (int i = 0; i < 24; i++) begin
            code    = 5'(16 + $urandom_range(0, 7));
            pattern = $urandom_range(0, 7);
            a       = {$urandom, $urandom};
            b       = {$urandom, $urandom};
            case (pattern)
                0: b = (code >= 5'd20) ? {b[63:32], 32'd0} : 64'd0;
                1: begin
                    a = (code >= 5'd20) ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = (code >= 5'd20) ? {b[63:32], 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                2: b = 64'($urandom_range(1, 20));
                3: b = -64'($urandom_range(1, 20));
                4: a = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            model(code, a, b, exp_val, exp_lat);
            runOp($sformatf("rand%0d code%0d", i, code), code, a, b, exp_val, exp_lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
